// File: rtl/maxpool_1d_stream_if.sv
// Stream bundle for the 1-D max-pool block: one valid-qualified vector per cycle
// in each direction, no back-pressure.
interface maxpool_1d_stream_if #(
    parameter int NO_CH = 10,
    parameter int BW    = 3
);
    logic                       vld_in;
    logic [NO_CH-1:0][BW-1:0]   data_in;
    logic                       last_in;
    logic                       vld_out;
    logic [NO_CH-1:0][BW-1:0]   data_out;
    logic                       last_out;

    modport slave (
        input  vld_in, data_in, last_in,
        output vld_out, data_out, last_out
    );

    modport master (
        output vld_in, data_in, last_in,
        input  vld_out, data_out, last_out
    );
endinterface

// File: rtl/maxpool_1d_stream.sv
// Streaming per-channel max pooling over non-overlapping windows of POOL accepted
// samples; a frame's last sample closes a partial window early.
module maxpool_1d_stream #(
    parameter int NO_CH = 10,
    parameter int BW    = 3,
    parameter int POOL  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    maxpool_1d_stream_if.slave    pool_io
);
    localparam int CW = (POOL > 1) ? $clog2(POOL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(POOL - 1);

    logic [CW-1:0]              cnt_q, cnt_d;
    logic [NO_CH-1:0][BW-1:0]   acc_q, acc_d;
    logic [NO_CH-1:0][BW-1:0]   dout_q, dout_d;
    logic                       vld_q, vld_d;
    logic                       last_q, last_d;
    logic [NO_CH-1:0][BW-1:0]   win_max;
    logic                       close;

    always_comb begin
        win_max = '0;
        // The first sample of a window replaces whatever acc still holds.
        for (int unsigned i = 0; i < NO_CH; i++) begin
            if (cnt_q == '0 || pool_io.data_in[i] > acc_q[i]) begin
                win_max[i] = pool_io.data_in[i];
            end else begin
                win_max[i] = acc_q[i];
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        dout_d = dout_q;
        last_d = last_q;
        vld_d  = 1'b0;
        close  = pool_io.vld_in && (cnt_q == CNT_LAST || pool_io.last_in);
        if (pool_io.vld_in) begin
            if (close) begin
                dout_d = win_max;
                last_d = pool_io.last_in;
                vld_d  = 1'b1;
                cnt_d  = '0;
            end else begin
                acc_d = win_max;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            dout_q <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    assign pool_io.vld_out  = vld_q;
    assign pool_io.data_out = dout_q;
    assign pool_io.last_out = last_q;
endmodule

// File: doc/maxpool_1d_stream.md
MAXPOOL_1D_STREAM -- requirements
Module: maxpool_1d_stream

Interface
REQ-001 SHALL have parameter NO_CH, default 10: number of channels per input vector.
REQ-002 SHALL have parameter BW, default 3: bits per channel value (unsigned quantized activation).
REQ-003 SHALL have parameter POOL, default 2: window length and stride in accepted samples; legal range 1..16.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port vld_in  input  1  data_in/last_in valid this cycle.
REQ-007 SHALL have port data_in  input  [NO_CH-1:0][BW-1:0]  quantized activation vector.
REQ-008 SHALL have port last_in  input  1  final sample of frame; qualified by vld_in.
REQ-009 SHALL have port vld_out  output  1  single-cycle pulse: data_out/last_out valid.
REQ-010 SHALL have port data_out  output  [NO_CH-1:0][BW-1:0]  per-channel window maximum.
REQ-011 SHALL have port last_out  output  1  pooled sample closes the frame; qualified by vld_out.

Function
REQ-012 SHALL hold a window counter cnt (0..POOL-1) and a per-channel running-max register acc[NO_CH].
REQ-013 SHALL change no state when vld_in=0; gaps of any length between valid samples are legal.
REQ-014 SHALL treat all channel values and comparisons as unsigned BW-bit.
REQ-015 SHALL compute, per channel, m = data_in[i] when cnt=0, else max(acc[i], data_in[i]).
REQ-016 SHALL, on an accepted sample with cnt<POOL-1 and last_in=0, load acc <= m and increment cnt.
REQ-017 SHALL, on an accepted sample with cnt=POOL-1 or last_in=1 (window close), register data_out <= m, last_out <= last_in, set vld_out=1 the next cycle, and set cnt <= 0.
REQ-018 SHALL deassert vld_out in every cycle not immediately following a window close.
REQ-019 SHALL have latency of exactly 1 cycle from the accepted closing sample to vld_out.
REQ-020 SHALL, for a last_in arriving in a partial window, emit the max over only the samples received since the previous close; no padding, no discarded samples.
REQ-021 SHALL, for last_in on a sample that also completes a full window, emit one output only, with last_out=1.
REQ-022 SHALL, after any close, start the next window with the next accepted sample (stride = POOL, non-overlapping).
REQ-023 SHALL, for POOL=1, pass each accepted sample to data_out with 1-cycle latency, one output per input.
REQ-024 SHALL hold data_out and last_out stable between closes; their values are only defined when vld_out=1.
REQ-025 SHALL sustain throughput of one accepted input per cycle with no back-pressure.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set cnt=0, acc=0, vld_out=0, last_out=0, data_out=0, ignoring vld_in that cycle.
REQ-027 SHALL discard any partial window on reset mid-frame; the first accepted sample after rst deasserts starts a fresh window.
REQ-028 SHALL, when rst is asserted the cycle after a close, still force vld_out=0 in the following cycle (reset overrides the pending pulse).

Verification
REQ-029 SHALL cover NO_CH=2, BW=3, POOL=2: back-to-back inputs {3,5},{6,1},{2,2},{7,0} with last_in on the 4th -> vld_out pulses 1 cycle after 2nd and 4th: {6,5} last_out=0, {7,2} last_out=1.
REQ-030 SHALL cover the same data with 3 idle cycles between each input -> identical outputs, each vld_out pulse exactly 1 cycle after its closing sample, single-cycle width.
REQ-031 SHALL cover POOL=4, inputs {1,7},{4,0},{2,3} with last_in on the 3rd -> one output {4,7} last_out=1; next frame {5,5}x4 -> {5,5} last_out=0 (no stale max carried over).
REQ-032 SHALL cover reset mid-window: POOL=2, accept {7,7}, assert rst one cycle, then accept {1,2},{3,0} -> single output {3,2}; no output reflecting {7,7}.
REQ-033 SHALL cover POOL=1: 8 consecutive random vectors with last_in on the 8th -> 8 outputs equal to inputs, 1-cycle latency, last_out only on the 8th.
REQ-034 SHALL cover all-zero and all-max (7) vectors across a window boundary -> outputs {0,0} and {7,7} exactly, confirming unsigned compare and no wrap.
